// File: rtl/alu_pkg.sv
// Opcode encodings and helpers shared by the pipelined ALU and its core.
package alu_pkg;

  localparam int ALU_FUNC_W = 4;

  localparam logic [ALU_FUNC_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_FUNC_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_FUNC_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_FUNC_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_FUNC_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_FUNC_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_FUNC_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_FUNC_W-1:0] ALU_SLTU = 4'd9;

  // Encodings above SLTU are reserved and reported as illegal.
  function automatic logic is_legal_func(input logic [ALU_FUNC_W-1:0] f);
    return (f <= ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus zero/carry/overflow/illegal flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_FUNC_W-1:0] func_i,
  input  logic [WIDTH-1:0]      op1_i,
  input  logic [WIDTH-1:0]      op2_i,
  output logic [WIDTH-1:0]      result_o,
  output logic                  zero_o,
  output logic                  carry_o,
  output logic                  ovf_o,
  output logic                  illegal_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          diff;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] sra;
  logic                    slt;
  logic                    sltu;
  logic                    legal;

  // Borrow of the subtraction lands in the extra top bit of diff.
  assign sum   = {1'b0, op1_i} + {1'b0, op2_i};
  assign diff  = {1'b0, op1_i} - {1'b0, op2_i};
  assign shamt = op2_i[SHW-1:0];
  assign sra   = $signed(op1_i) >>> shamt;
  assign slt   = $signed(op1_i) < $signed(op2_i);
  assign sltu  = op1_i < op2_i;
  assign legal = is_legal_func(func_i);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    case (func_i)
      ALU_ADD: begin
        result_o = sum[WIDTH-1:0];
        carry_o  = sum[WIDTH];
        ovf_o    = (op1_i[WIDTH-1] == op2_i[WIDTH-1]) && (sum[WIDTH-1] != op1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        result_o = diff[WIDTH-1:0];
        carry_o  = diff[WIDTH];
        ovf_o    = (op1_i[WIDTH-1] != op2_i[WIDTH-1]) && (diff[WIDTH-1] != op1_i[WIDTH-1]);
      end
      ALU_AND:  result_o = op1_i & op2_i;
      ALU_OR:   result_o = op1_i | op2_i;
      ALU_XOR:  result_o = op1_i ^ op2_i;
      ALU_SLL:  result_o = op1_i << shamt;
      ALU_SRL:  result_o = op1_i >> shamt;
      ALU_SRA:  result_o = sra;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, sltu};
      default:  result_o = '0;
    endcase
  end

  // Illegal opcodes report only the illegal flag, even though the result is 0.
  assign zero_o    = legal && (result_o == '0);
  assign illegal_o = !legal;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, tag sideband and flush.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_FUNC_W-1:0] in_func,
  input  logic [WIDTH-1:0]      in_op1,
  input  logic [WIDTH-1:0]      in_op2,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_ovf,
  output logic                  out_illegal
);

  logic                  s1_valid_q, s1_valid_d;
  logic [ALU_FUNC_W-1:0] s1_func_q;
  logic [WIDTH-1:0]      s1_op1_q;
  logic [WIDTH-1:0]      s1_op2_q;
  logic [TAG_W-1:0]      s1_tag_q;

  logic                  s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]      s2_result_q;
  logic [TAG_W-1:0]      s2_tag_q;
  logic                  s2_zero_q, s2_carry_q, s2_ovf_q, s2_illegal_q;

  logic [WIDTH-1:0]      core_result;
  logic                  core_zero, core_carry, core_ovf, core_illegal;

  logic                  s2_adv, s1_adv, accept, s2_load;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !flush && rst_n;
  assign accept   = in_valid && in_ready;
  assign s2_load  = !flush && s2_adv && s1_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_adv) s2_valid_d = s1_valid_q;
      if (s1_adv) s1_valid_d = accept;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Operand registers need no reset: they are qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_func_q <= in_func;
      s1_op1_q  <= in_op1;
      s1_op2_q  <= in_op2;
      s1_tag_q  <= in_tag;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .func_i    (s1_func_q),
    .op1_i     (s1_op1_q),
    .op2_i     (s1_op2_q),
    .result_o  (core_result),
    .zero_o    (core_zero),
    .carry_o   (core_carry),
    .ovf_o     (core_ovf),
    .illegal_o (core_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
      s2_zero_q    <= 1'b0;
      s2_carry_q   <= 1'b0;
      s2_ovf_q     <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else if (s2_load) begin
      s2_result_q  <= core_result;
      s2_tag_q     <= s1_tag_q;
      s2_zero_q    <= core_zero;
      s2_carry_q   <= core_carry;
      s2_ovf_q     <= core_ovf;
      s2_illegal_q <= core_illegal;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_zero    = s2_zero_q;
  assign out_carry   = s2_carry_q;
  assign out_ovf     = s2_ovf_q;
  assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a 32-bit and an 8-bit instance on one clock.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_func;
  logic [31:0] in_op1, in_op2, out_result;
  logic [4:0]  in_tag, out_tag;
  logic        out_zero, out_carry, out_ovf, out_illegal;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0]  b_in_func;
  logic [7:0]  b_in_op1, b_in_op2, b_out_result;
  logic [4:0]  b_in_tag, b_out_tag;
  logic        b_out_zero, b_out_carry, b_out_ovf, b_out_illegal;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_illegal(out_illegal)
  );

  alu_pipe #(.WIDTH(8), .TAG_W(5)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_func(b_in_func),
    .in_op1(b_in_op1), .in_op2(b_in_op2), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .out_tag(b_out_tag), .out_zero(b_out_zero), .out_carry(b_out_carry),
    .out_ovf(b_out_ovf), .out_illegal(b_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Single op on the 32-bit pipe with out_ready high; flags are {zero,carry,ovf,illegal}.
  task automatic op32(input string nm, input logic [3:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t,
                      input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_func = f; in_op1 = a; in_op2 = b; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
    check_val({nm, ".lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check_val({nm, ".valid"}, 64'(out_valid), 64'd1);
    check_val({nm, ".result"}, 64'(out_result), 64'(er));
    check_val({nm, ".tag"}, 64'(out_tag), 64'(t));
    check_val({nm, ".flags"}, 64'({out_zero, out_carry, out_ovf, out_illegal}), 64'(ef));
    $display("op32 %s result=0x%08h tag=%0d zcoi=%b", nm, out_result, out_tag,
             {out_zero, out_carry, out_ovf, out_illegal});
  endtask

  task automatic op8(input string nm, input logic [3:0] f, input logic [7:0] a,
                     input logic [7:0] b, input logic [4:0] t,
                     input logic [7:0] er, input logic [3:0] ef);
    @(negedge clk);
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_func = f; b_in_op1 = a; b_in_op2 = b; b_in_tag = t;
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    check_val({nm, ".valid"}, 64'(b_out_valid), 64'd1);
    check_val({nm, ".result"}, 64'(b_out_result), 64'(er));
    check_val({nm, ".tag"}, 64'(b_out_tag), 64'(t));
    check_val({nm, ".flags"}, 64'({b_out_zero, b_out_carry, b_out_ovf, b_out_illegal}), 64'(ef));
    $display("op8 %s result=0x%02h tag=%0d zcoi=%b", nm, b_out_result, b_out_tag,
             {b_out_zero, b_out_carry, b_out_ovf, b_out_illegal});
  endtask

  // Backpressure stream vectors, tags 1..5, results worked out by hand.
  logic [3:0]  bp_f   [5];
  logic [31:0] bp_a   [5];
  logic [31:0] bp_b   [5];
  logic [31:0] bp_res [5];
  bit          bp_pat [12];

  initial begin
    int sent, recv, inflight;
    logic stall_prev;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;

    bp_f[0] = 4'd0; bp_a[0] = 32'd5;      bp_b[0] = 32'd3;      bp_res[0] = 32'd8;
    bp_f[1] = 4'd1; bp_a[1] = 32'd10;     bp_b[1] = 32'd4;      bp_res[1] = 32'd6;
    bp_f[2] = 4'd4; bp_a[2] = 32'hF0F0;   bp_b[2] = 32'h0FF0;   bp_res[2] = 32'hFF00;
    bp_f[3] = 4'd5; bp_a[3] = 32'd1;      bp_b[3] = 32'd8;      bp_res[3] = 32'h100;
    bp_f[4] = 4'd3; bp_a[4] = 32'hA0;     bp_b[4] = 32'h05;     bp_res[4] = 32'hA5;
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_func = '0; in_op1 = '0; in_op2 = '0; in_tag = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_func = '0; b_in_op1 = '0; b_in_op2 = '0; b_in_tag = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst.valid", 64'(out_valid), 64'd0);
    check_val("rst.result", 64'(out_result), 64'd0);
    check_val("rst.tag", 64'(out_tag), 64'd0);
    check_val("rst.flags", 64'({out_zero, out_carry, out_ovf, out_illegal}), 64'd0);
    check_val("rst.in_ready", 64'(in_ready), 64'd0);
    check_val("rst.b_valid", 64'(b_out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check_val("rst.release_ready", 64'(in_ready), 64'd1);

    // Back-to-back ADD then SUB, results on consecutive cycles
    @(negedge clk);
    in_valid = 1'b1; in_func = 4'd0; in_op1 = 32'hFFFF_FFFF; in_op2 = 32'd1; in_tag = 5'd3;
    @(negedge clk);
    check_val("b2b.lat1", 64'(out_valid), 64'd0);
    in_func = 4'd1; in_op1 = 32'h8000_0000; in_op2 = 32'd1; in_tag = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("b2b.add.valid", 64'(out_valid), 64'd1);
    check_val("b2b.add.result", 64'(out_result), 64'd0);
    check_val("b2b.add.tag", 64'(out_tag), 64'd3);
    check_val("b2b.add.flags", 64'({out_zero, out_carry, out_ovf, out_illegal}), 64'b1100);
    $display("b2b add result=0x%08h", out_result);
    @(negedge clk);
    check_val("b2b.sub.valid", 64'(out_valid), 64'd1);
    check_val("b2b.sub.result", 64'(out_result), 64'h7FFF_FFFF);
    check_val("b2b.sub.tag", 64'(out_tag), 64'd4);
    check_val("b2b.sub.flags", 64'({out_zero, out_carry, out_ovf, out_illegal}), 64'b0010);
    $display("b2b sub result=0x%08h", out_result);

    // Individual operations
    op32("sra",   4'd7,  32'h8000_0010, 32'h24,        5'd1, 32'hF800_0001, 4'b0000);
    op32("slt",   4'd8,  32'hFFFF_FFFF, 32'd1,         5'd2, 32'd1,         4'b0000);
    op32("sltu",  4'd9,  32'hFFFF_FFFF, 32'd1,         5'd3, 32'd0,         4'b1000);
    op32("ill12", 4'd12, 32'h1234_5678, 32'h9,         5'd4, 32'd0,         4'b0001);
    op32("subbw", 4'd1,  32'd1,         32'd2,         5'd5, 32'hFFFF_FFFF, 4'b0100);
    op32("and",   4'd2,  32'hFF00_FF00, 32'h0FF0_0FF0, 5'd6, 32'h0F00_0F00, 4'b0000);
    op32("srl",   4'd6,  32'h8000_0000, 32'd31,        5'd7, 32'd1,         4'b0000);
    op32("sllmod",4'd5,  32'h1,         32'h21,        5'd8, 32'h2,         4'b0000);

    // Backpressure stream with toggling out_ready
    sent = 0; recv = 0; stall_prev = 1'b0; hold_res = '0; hold_tag = '0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (stall_prev) begin
        check_val("bp.hold.valid", 64'(out_valid), 64'd1);
        check_val("bp.hold.result", 64'(out_result), 64'(hold_res));
        check_val("bp.hold.tag", 64'(out_tag), 64'(hold_tag));
      end
      out_ready = (cyc < 12) ? bp_pat[cyc] : 1'b1;
      if (sent < 5) begin
        in_valid = 1'b1; in_func = bp_f[sent]; in_op1 = bp_a[sent];
        in_op2 = bp_b[sent]; in_tag = 5'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      inflight = sent - recv;
      check_val("bp.in_ready", 64'(in_ready), 64'(!(inflight == 2 && !out_ready)));
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (recv < 5) begin
          check_val("bp.result", 64'(out_result), 64'(bp_res[recv]));
          check_val("bp.tag", 64'(out_tag), 64'(recv + 1));
          $display("bp recv tag=%0d result=0x%08h", out_tag, out_result);
        end else begin
          check_val("bp.extra", 64'(out_tag), 64'd0);
        end
        recv++;
      end
      stall_prev = out_valid && !out_ready;
      hold_res = out_result;
      hold_tag = out_tag;
    end
    check_val("bp.count", 64'(recv), 64'd5);
    in_valid = 1'b0; out_ready = 1'b1;

    // Flush with both stages full and stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_func = 4'd0; in_op1 = 32'd1; in_op2 = 32'd1; in_tag = 5'd7;
    @(negedge clk);
    in_tag = 5'd8;
    @(negedge clk);
    check_val("fl.full.valid", 64'(out_valid), 64'd1);
    check_val("fl.full.in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; out_ready = 1'b1; in_tag = 5'd9;
    #1;
    check_val("fl.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check_val("fl.valid", 64'(out_valid), 64'd0);
    in_func = 4'd0; in_op1 = 32'd20; in_op2 = 32'd22; in_tag = 5'd10;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("fl.gap", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_val("fl.next.valid", 64'(out_valid), 64'd1);
    check_val("fl.next.tag", 64'(out_tag), 64'd10);
    check_val("fl.next.result", 64'(out_result), 64'd42);
    @(negedge clk);
    check_val("fl.drain", 64'(out_valid), 64'd0);

    // Reset mid-stream
    in_valid = 1'b1; in_func = 4'd0; in_op1 = 32'd5; in_op2 = 32'd6; in_tag = 5'd11;
    @(negedge clk);
    in_tag = 5'd12;
    @(negedge clk);
    check_val("mr.pre.valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check_val("mr.valid", 64'(out_valid), 64'd0);
    check_val("mr.result", 64'(out_result), 64'd0);
    check_val("mr.tag", 64'(out_tag), 64'd0);
    check_val("mr.in_ready_low", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check_val("mr.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check_val("mr.stale1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_val("mr.stale2", 64'(out_valid), 64'd0);

    // 8-bit instance
    op8("w8.add", 4'd0, 8'h7F, 8'h01, 5'd1, 8'h80, 4'b0010);
    op8("w8.sll", 4'd5, 8'h01, 8'h09, 5'd2, 8'h02, 4'b0000);
    op8("w8.addc", 4'd0, 8'hFF, 8'h01, 5'd3, 8'h00, 4'b1100);
    op8("w8.sra", 4'd7, 8'h90, 8'h02, 5'd4, 8'hE4, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational ALU in the processing unit.
- Widens the opcode to 4 bits and adds XOR, shifts and set-less-than, with zero/carry/overflow/illegal flags.
- Carries a tag alongside each operation and uses valid/ready handshakes on both sides, so the execute stage can stall or flush it.
- Sits between operand fetch and writeback in the CPU core.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are 8, 16, 32, 64.
- TAG_W, 5, width of the sideband tag (destination register index) carried with each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- in_func  in  4  opcode (alu_pkg encoding).
- in_op1  in  WIDTH  operand 1.
- in_op2  in  WIDTH  operand 2; low $clog2(WIDTH) bits are the shift amount.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  result == 0.
- out_carry  out  1  ADD: unsigned carry-out; SUB: 1 when op1 < op2 unsigned (borrow); other ops: 0.
- out_ovf  out  1  signed overflow for ADD/SUB; other ops: 0.
- out_illegal  out  1  opcode not defined.

Behaviour:
Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU.
- 10-15 are illegal: result 0, out_illegal=1, all other flags 0, and the operation still flows through the pipe.
- SLT/SLTU return 1 or 0, zero-extended to WIDTH.
- Shift amount is taken modulo WIDTH. SRA replicates op1[WIDTH-1].
- All arithmetic is modulo 2^WIDTH. Carry and overflow are computed on a WIDTH+1-bit sum.

Stage 1 (S1):
- Registers func, op1, op2 and tag, plus a valid bit, on each handshake (in_valid && in_ready).

Stage 2 (S2):
- Computes on the S1 contents and registers result, flags, tag and a valid bit.
- out_* are driven directly from S2 registers, with no combinational path from in_* to out_*.

Handshake and latency:
- Accept at edge N gives out_valid=1 after edge N+1 (2-cycle latency) if not stalled.
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv. This is combinational from out_ready, with no skid buffer.
- Full throughput is 1 operation/cycle with out_ready held high.
- While out_valid && !out_ready: out_* are held stable, and S1 holds if valid.
- Bubbles collapse: an empty S2 accepts from S1 even when out_ready=0.
- Ordering is strictly in-order; no operation is dropped or duplicated except by flush or reset.

Flush:
- At the next edge, s1_valid=0 and s2_valid=0.
- An input offered in the same cycle as flush is not accepted; in_ready is forced to 0 while flush=1.
- Flush has priority over any handshake.

Reset:
- On an edge with rst_n=0: s1_valid=0 and s2_valid=0, so out_valid=0.
- out_result=0, out_tag=0, and all flags are 0.
- Reset mid-operation discards all in-flight operations.
- in_ready is 0 while rst_n=0 and 1 on the first cycle after release.
- Reset has priority over flush.

Data registers:
- Data registers are not required to reset except the S2 output registers listed above.

Decomposition:
- Package alu_pkg holds:
  - localparams for the 4-bit opcode encodings (ALU_ADD … ALU_SLTU);
  - ALU_FUNC_W=4;
  - a function is_legal_func().
- One combinational sub-module, alu_core (WIDTH param): func/op1/op2 → result, zero, carry, ovf, illegal. It is instantiated between S1 and S2.
- Pipeline registers and handshake logic stay in alu_pipe.

Test Plan:
- WIDTH=32, out_ready=1, back-to-back ADD 0xFFFFFFFF+1 then SUB 0x80000000-1 → outputs on consecutive cycles, latency 2:
  - first: result=0, zero=1, carry=1, ovf=0;
  - second: result=0x7FFFFFFF, ovf=1, carry=0.
- SRA op1=0x80000010, op2=0x24 (shift 4) → 0xF8000001. SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0. func=12 → result=0, illegal=1.
- Backpressure: stream 5 tagged operations (tags 1..5) with out_ready toggling 1,0,0,1,0,1,… →
  - all 5 results emerge in order with correct tags, none lost or duplicated;
  - out_* are stable while out_valid && !out_ready;
  - in_ready drops only when both stages are full and stalled.
- Flush with both stages valid and out_ready=0 → out_valid=0 next cycle, and the next accepted operation produces the only subsequent result.
- Assert rst_n=0 for 1 cycle mid-stream → out_valid=0 and out_result=0 after the edge, in_ready=1 the cycle after release, no stale results.
- WIDTH=8: ADD 0x7F+0x01 → result 0x80, ovf=1. SLL 0x01 by op2=9 → 0x02 (shift mod 8).
